e1_buf_mfifo: RTL and testbench

E1_BUF_MFIFO -- requirements
Module: e1_buf_mfifo

---
 rtl/e1_buf_mfifo.sv | 143 ++++++++++++++
 tb/tb_e1_buf_mfifo.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/e1_buf_mfifo.sv
// Elastic E1 loopback buffer: a FIFO of whole 512-byte multiframes between the RX writer and the TX reader.
// Optional sticky ovf/udf error flags are built only when E1_BUF_MFIFO_STATUS_EN is defined.
module e1_buf_mfifo #(
  parameter int MFW = 7,
  parameter int MB  = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     buf_rx_data,
  input  logic [4:0]     buf_rx_ts,
  input  logic [3:0]     buf_rx_frame,
  input  logic [MFW-1:0] buf_rx_mf,
  input  logic           buf_rx_we,
  output logic           buf_rx_rdy,
  output logic [7:0]     buf_tx_data,
  input  logic [4:0]     buf_tx_ts,
  input  logic [3:0]     buf_tx_frame,
  input  logic [MFW-1:0] buf_tx_mf,
  input  logic           buf_tx_re,
  output logic           buf_tx_rdy,
  input  logic           flush,
  output logic [MB:0]    level,
  output logic           ovf,
  output logic           udf
);

  localparam int AW = MB + 9;
  localparam logic [MB-1:0] PTR_ONE = (MB)'(1'b1);
  localparam logic [MB:0]   LVL_ONE = (MB+1)'(1'b1);

  logic [7:0]    mem_r [2**AW];
  logic [MB-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [MB:0]   level_r, level_nxt_s;
  logic          rx_rdy_r, tx_rdy_r;
  logic [7:0]    tx_data_r;
  logic          wr_ok_s, rd_ok_s, rx_last_s, tx_last_s, inc_s, dec_s;
  logic          unused_mf_s;

  // The multiframe number is implied by the pointers, so the interface copy is not needed.
  assign unused_mf_s = ^{buf_rx_mf, buf_tx_mf};

  assign wr_ok_s   = buf_rx_we & rx_rdy_r;
  assign rd_ok_s   = buf_tx_re & tx_rdy_r;
  assign rx_last_s = (buf_rx_ts == 5'd31) && (buf_rx_frame == 4'd15);
  assign tx_last_s = (buf_tx_ts == 5'd31) && (buf_tx_frame == 4'd15);
  assign inc_s     = wr_ok_s & rx_last_s;
  assign dec_s     = rd_ok_s & tx_last_s;

  // Next pointer and level; flush wins over any same-cycle completion.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    level_nxt_s  = level_r;
    if (flush) begin
      wr_ptr_nxt_s = '0;
      rd_ptr_nxt_s = '0;
      level_nxt_s  = '0;
    end else begin
      if (inc_s) begin
        wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (dec_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      if (inc_s && !dec_s) begin
        level_nxt_s = level_r + LVL_ONE;
      end else if (dec_s && !inc_s) begin
        level_nxt_s = level_r - LVL_ONE;
      end else begin
        level_nxt_s = level_r;
      end
    end
  end

  // Pointer, level and ready state; ready flags are precomputed so they leave a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
      rx_rdy_r <= 1'b1;
      tx_rdy_r <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      level_r  <= level_nxt_s;
      rx_rdy_r <= ~level_nxt_s[MB];
      tx_rdy_r <= |level_nxt_s;
    end
  end

  // Multiframe storage, deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[{wr_ptr_r, buf_rx_frame, buf_rx_ts}] <= buf_rx_data;
    end
  end

  // Read data register; an underflowing read returns idle 8'hFF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data_r <= 8'hFF;
    end else if (rd_ok_s) begin
      tx_data_r <= mem_r[{rd_ptr_r, buf_tx_frame, buf_tx_ts}];
    end else if (buf_tx_re) begin
      tx_data_r <= 8'hFF;
    end
  end

`ifdef E1_BUF_MFIFO_STATUS_EN
  logic ovf_r, udf_r;

  // Sticky error flags, cleared only by flush or reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
    end else if (flush) begin
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r | (buf_rx_we & ~rx_rdy_r);
      udf_r <= udf_r | (buf_tx_re & ~tx_rdy_r);
    end
  end

  assign ovf = ovf_r;
  assign udf = udf_r;
`else
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

  assign buf_rx_rdy  = rx_rdy_r;
  assign buf_tx_rdy  = tx_rdy_r;
  assign buf_tx_data = tx_data_r;
  assign level       = level_r;

endmodule

// File: tb/tb_e1_buf_mfifo.sv
// Bench for e1_buf_mfifo: directed phases with random payloads, checked against a multiframe-queue model.
module tb_e1_buf_mfifo;
  localparam int MFW = 7;
  localparam int MB  = 1;
  localparam int NMF = 1 << MB;
  localparam int MFB = 512;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [7:0]     buf_rx_data = 8'h00;
  logic [4:0]     buf_rx_ts = 5'd0;
  logic [3:0]     buf_rx_frame = 4'd0;
  logic [MFW-1:0] buf_rx_mf = '0;
  logic           buf_rx_we = 1'b0;
  logic           buf_rx_rdy;
  logic [7:0]     buf_tx_data;
  logic [4:0]     buf_tx_ts = 5'd0;
  logic [3:0]     buf_tx_frame = 4'd0;
  logic [MFW-1:0] buf_tx_mf = '0;
  logic           buf_tx_re = 1'b0;
  logic           buf_tx_rdy;
  logic           flush = 1'b0;
  logic [MB:0]    level;
  logic           ovf, udf;

  e1_buf_mfifo #(.MFW(MFW), .MB(MB)) dut (
    .clk(clk), .rst(rst),
    .buf_rx_data(buf_rx_data), .buf_rx_ts(buf_rx_ts), .buf_rx_frame(buf_rx_frame),
    .buf_rx_mf(buf_rx_mf), .buf_rx_we(buf_rx_we), .buf_rx_rdy(buf_rx_rdy),
    .buf_tx_data(buf_tx_data), .buf_tx_ts(buf_tx_ts), .buf_tx_frame(buf_tx_frame),
    .buf_tx_mf(buf_tx_mf), .buf_tx_re(buf_tx_re), .buf_tx_rdy(buf_tx_rdy),
    .flush(flush), .level(level), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;
  int wi = 0;
  int ri = 0;
  logic [7:0] dq[$];
  logic [7:0] part [MFB];
  logic [7:0] exp_data = 8'hFF;
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    int lvl;
    lvl = dq.size() / MFB;
    chk("tx_data", 32'(buf_tx_data), 32'(exp_data));
    chk("level", 32'(level), 32'(lvl));
    chk("rx_rdy", 32'(buf_rx_rdy), 32'(lvl < NMF));
    chk("tx_rdy", 32'(buf_tx_rdy), 32'(lvl != 0));
`ifdef E1_BUF_MFIFO_STATUS_EN
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("udf", 32'(udf), 32'(m_udf));
`else
    chk("ovf", 32'(ovf), 32'd0);
    chk("udf", 32'(udf), 32'd0);
`endif
  endtask

  // One clock of stimulus; the writer/reader positions wi/ri advance only on accepted accesses.
  task automatic step(input bit we, input logic [7:0] d, input bit re, input bit fl);
    int lvl;
    bit rx_ok, tx_ok;
    lvl = dq.size() / MFB;
    buf_rx_we    = we;
    buf_rx_data  = d;
    buf_rx_ts    = wi[4:0];
    buf_rx_frame = wi[8:5];
    buf_rx_mf    = MFW'($urandom);
    buf_tx_re    = re;
    buf_tx_ts    = ri[4:0];
    buf_tx_frame = ri[8:5];
    buf_tx_mf    = MFW'($urandom);
    flush        = fl;
    rx_ok = we && (lvl < NMF);
    tx_ok = re && (lvl != 0);
    if (tx_ok) exp_data = dq[ri];
    else if (re) exp_data = 8'hFF;
    if (we && !rx_ok) m_ovf = 1'b1;
    if (re && !tx_ok) m_udf = 1'b1;
    @(posedge clk);
    #1;
    if (fl) begin
      dq.delete();
      wi = 0;
      ri = 0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (tx_ok) begin
        if (ri == MFB - 1) begin
          repeat (MFB) void'(dq.pop_front());
          ri = 0;
        end else ri++;
      end
      if (rx_ok) begin
        part[wi] = d;
        if (wi == MFB - 1) begin
          for (int i = 0; i < MFB; i++) dq.push_back(part[i]);
          wi = 0;
        end else wi++;
      end
    end
    buf_rx_we = 1'b0;
    buf_tx_re = 1'b0;
    flush     = 1'b0;
    check_all();
  endtask

  task automatic write_mf(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
  endtask

  task automatic read_mf(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    logic [7:0] d;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all();

    // Single multiframe with data = ts ^ frame, then read back in the same order.
    for (int i = 0; i < MFB; i++) begin
      d = {3'b000, wi[4:0]} ^ {4'b0000, wi[8:5]};
      step(1'b1, d, 1'b0, 1'b0);
    end
    read_mf(MFB);

    // Underflow read, then fill to full and attempt a dropped write.
    step(1'b0, 8'h00, 1'b1, 1'b0);
    write_mf(2 * MFB);
    step(1'b1, 8'h55, 1'b0, 1'b0);

    // Drain to level 1, then run write and read in lockstep so both complete together.
    read_mf(MFB);
    for (int i = 0; i < MFB; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0);
    read_mf(MFB);

    // Pointer wrap-around over five multiframes.
    for (int k = 0; k < 5; k++) begin
      write_mf(MFB);
      read_mf(MFB);
    end

    // Random gating of both sides, exercising full, empty and drop cases.
    for (int i = 0; i < 3000; i++)
      step(1'($urandom), 8'($urandom), 1'($urandom_range(0, 2) == 0), 1'b0);

    // Flush with a complete plus a half-written multiframe and set error flags.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    write_mf(MFB + MFB / 2);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    write_mf(MFB);
    read_mf(MFB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
